serial_shift_scaler: RTL and testbench

//  Sequential arithmetic scaler. Multiplies (left shift) or divides (right shift)
//  a signed two's-complement word by 2^amt, one bit position per clock.

---
 rtl/serial_shift_scaler_if.sv | 25 ++
 rtl/serial_shift_scaler.sv | 122 ++++++++++++
 tb/tb_serial_shift_scaler.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_shift_scaler_if.sv
// Handshake bundle for serial_shift_scaler: request side (in_*) and result side (out_*).
interface serial_shift_scaler_if #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_dir, in_amt, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_dir, in_amt, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/serial_shift_scaler.sv
// Sequential signed scaler: multiplies or divides by 2^amt one bit per clock,
// with a sticky signed-overflow flag for the multiply direction.
module serial_shift_scaler #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_shift_scaler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] out_data_r;
    logic [AMT_W-1:0] cnt_r;
    logic             dir_r;
    logic             ovf_r;
    logic             out_ovf_r;
    logic             accept_s;
    logic             step_s;
    logic             finish_s;

    function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], 1'b0};
    endfunction

    function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v);
        return {v[WIDTH-1], v[WIDTH-1:1]};
    endfunction

    // A left step loses the sign when the two top bits differ before the shift.
    function automatic logic sign_change(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ^ v[WIDTH-2];
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_s = 1'b1;
                    state_s  = SHIFT;
                end else begin
                    state_s  = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == '0) begin
                    finish_s = 1'b1;
                    state_s  = DONE;
                end else begin
                    step_s   = 1'b1;
                    state_s  = SHIFT;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand capture, one-bit shift steps and result registration on entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= '0;
            cnt_r      <= '0;
            dir_r      <= 1'b0;
            ovf_r      <= 1'b0;
            out_data_r <= '0;
            out_ovf_r  <= 1'b0;
        end else if (accept_s) begin
            acc_r <= bus.in_data;
            cnt_r <= bus.in_amt;
            dir_r <= bus.in_dir;
            ovf_r <= 1'b0;
        end else if (step_s) begin
            cnt_r <= cnt_r - CNT_ONE;
            if (dir_r) begin
                acc_r <= shift_right(acc_r);
            end else begin
                acc_r <= shift_left(acc_r);
                ovf_r <= ovf_r | sign_change(acc_r);
            end
        end else if (finish_s) begin
            out_data_r <= acc_r;
            out_ovf_r  <= ovf_r;
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.out_data  = out_data_r;
    assign bus.out_ovf   = out_ovf_r;
endmodule

// File: tb/tb_serial_shift_scaler.sv
// Directed and exhaustive self-checking bench for serial_shift_scaler (WIDTH=4, AMT_W=2).
module tb_serial_shift_scaler;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    serial_shift_scaler_if #(.WIDTH(4), .AMT_W(2)) bus ();

    serial_shift_scaler #(.WIDTH(4), .AMT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Independent arithmetic reference: true product range test and floor division.
    task automatic model(input logic [3:0] d, input logic dr, input logic [1:0] a,
                         output logic [3:0] r, output logic o);
        int sd;
        int p;
        int q;
        int div;
        sd  = int'($signed(d));
        div = 1 << a;
        if (!dr) begin
            p = sd * div;
            r = p[3:0];
            o = (p > 7) || (p < -8);
        end else begin
            q = sd / div;
            if ((sd < 0) && ((sd % div) != 0)) q = q - 1;
            r = q[3:0];
            o = 1'b0;
        end
    endtask

    // Full transaction with latency, result, ignored-input and handshake checks.
    task automatic do_op(input string tag, input logic [3:0] d, input logic dr,
                         input logic [1:0] a, input logic [3:0] exp_d, input logic exp_o);
        int n;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_dir    = dr;
        bus.in_amt    = a;
        check({tag, "_rdy"}, int'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = ~d;
        bus.in_dir   = ~dr;
        bus.in_amt   = ~a;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, int'(a) + 1);
        check({tag, "_data"}, int'(bus.out_data), int'(exp_d));
        check({tag, "_ovf"}, int'(bus.out_ovf), int'(exp_o));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_idle"}, int'({bus.in_ready, bus.out_valid}), 32'd2);
    endtask

    initial begin
        logic [3:0] md;
        logic       mo;
        int         n;
        n_assert      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'd0;
        bus.in_dir    = 1'b0;
        bus.in_amt    = 2'd0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_ready", int'(bus.in_ready), 32'd1);
        check("rst_valid", int'(bus.out_valid), 32'd0);
        check("rst_data", int'(bus.out_data), 32'd0);
        check("rst_ovf", int'(bus.out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_hold", int'({bus.in_ready, bus.out_valid}), 32'd2);

        do_op("mul3x2", 4'd3, 1'b0, 2'd1, 4'd6, 1'b0);
        do_op("mul3x4", 4'd3, 1'b0, 2'd2, 4'hC, 1'b1);
        do_op("mulm8x2", 4'h8, 1'b0, 2'd1, 4'h0, 1'b1);
        do_op("divm8", 4'h8, 1'b1, 2'd3, 4'hF, 1'b0);
        do_op("divm3", 4'hD, 1'b1, 2'd1, 4'hE, 1'b0);
        do_op("div7", 4'd7, 1'b1, 2'd2, 4'd1, 1'b0);
        do_op("pass_m5", 4'hB, 1'b0, 2'd0, 4'hB, 1'b0);

        // in_valid held high throughout: no second accept while busy or from DONE.
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd5;
        bus.in_dir   = 1'b0;
        bus.in_amt   = 2'd3;
        tick();
        bus.in_data = 4'd1;
        bus.in_amt  = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("busy_ready", int'(bus.in_ready), 32'd0);
        end
        tick();
        check("busy_valid", int'(bus.out_valid), 32'd1);
        check("busy_data", int'(bus.out_data), 32'd8);
        check("busy_ovf", int'(bus.out_ovf), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        check("no_bypass", int'({bus.in_ready, bus.out_valid}), 32'd2);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();

        // Backpressure in DONE with a pending request.
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd3;
        bus.in_dir   = 1'b0;
        bus.in_amt   = 2'd1;
        tick();
        bus.in_data = 4'd7;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_lat", n, 32'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", int'(bus.out_valid), 32'd1);
            check("bp_data", int'(bus.out_data), 32'd6);
            check("bp_ready", int'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_release", int'({bus.in_ready, bus.out_valid}), 32'd2);
        tick();
        check("bp_next_acc", int'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_next_data", int'(bus.out_data), 32'd14);
        check("bp_next_ovf", int'(bus.out_ovf), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Asynchronous reset in the middle of a shift.
        do_op("pre_rst", 4'd3, 1'b0, 2'd2, 4'hC, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd7;
        bus.in_dir   = 1'b0;
        bus.in_amt   = 2'd3;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("mid_shift", int'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("arst_valid", int'(bus.out_valid), 32'd0);
        check("arst_data", int'(bus.out_data), 32'd0);
        check("arst_ovf", int'(bus.out_ovf), 32'd0);
        check("arst_ready", int'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_idle", int'({bus.in_ready, bus.out_valid}), 32'd2);
        do_op("post_rst", 4'd1, 1'b0, 2'd2, 4'd4, 1'b0);

        // Exhaustive sweep against the arithmetic reference.
        for (int d = 0; d < 16; d++) begin
            for (int dr = 0; dr < 2; dr++) begin
                for (int a = 0; a < 4; a++) begin
                    model(4'(d), 1'(dr), 2'(a), md, mo);
                    do_op($sformatf("sweep_d%0d_r%0d_a%0d", d, dr, a), 4'(d), 1'(dr), 2'(a), md, mo);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
